// File: rtl/etapa_operandos_alu_if.sv
// -----------------------------------------------------------------------------
// etapa_operandos_alu_if
// Bundles the decode-side request, the forwarding sources, the flush and the
// ALU-side result bus of the ID/EX operand stage.
//   master : decode / forwarding / ALU side (drives requests, reads results)
//   slave  : the operand stage itself
// Signals:
//   entrada_valida/entrada_lista        decode handshake
//   dirA/dirB/datoA/datoB               source addresses and register data
//   inmediato/usar_inmediato            raw immediate and operand-B select
//   operacion/dir_destino/escribe_reg   pass-through fields
//   exmem_*/memwb_*                     forwarding sources
//   vaciar                              flush
//   salida_valida/salida_lista          ALU handshake
//   operandoA/operandoB/seleccionOperacion/dir_destino_out/escribe_reg_out
// -----------------------------------------------------------------------------
interface etapa_operandos_alu_if #(
    parameter int ANCHO     = 32,
    parameter int ANCHO_OP  = 3,
    parameter int ANCHO_DIR = 5,
    parameter int ANCHO_INM = 16
);
    logic                 entrada_valida;
    logic                 entrada_lista;
    logic [ANCHO_DIR-1:0] dirA;
    logic [ANCHO_DIR-1:0] dirB;
    logic [ANCHO-1:0]     datoA;
    logic [ANCHO-1:0]     datoB;
    logic [ANCHO_INM-1:0] inmediato;
    logic                 usar_inmediato;
    logic [ANCHO_OP-1:0]  operacion;
    logic [ANCHO_DIR-1:0] dir_destino;
    logic                 escribe_reg;
    logic                 exmem_escribe;
    logic [ANCHO_DIR-1:0] exmem_dir;
    logic [ANCHO-1:0]     exmem_dato;
    logic                 memwb_escribe;
    logic [ANCHO_DIR-1:0] memwb_dir;
    logic [ANCHO-1:0]     memwb_dato;
    logic                 vaciar;
    logic                 salida_lista;
    logic                 salida_valida;
    logic [ANCHO-1:0]     operandoA;
    logic [ANCHO-1:0]     operandoB;
    logic [ANCHO_OP-1:0]  seleccionOperacion;
    logic [ANCHO_DIR-1:0] dir_destino_out;
    logic                 escribe_reg_out;

    modport master (
        output entrada_valida, dirA, dirB, datoA, datoB, inmediato, usar_inmediato,
               operacion, dir_destino, escribe_reg,
               exmem_escribe, exmem_dir, exmem_dato,
               memwb_escribe, memwb_dir, memwb_dato,
               vaciar, salida_lista,
        input  entrada_lista, salida_valida, operandoA, operandoB,
               seleccionOperacion, dir_destino_out, escribe_reg_out
    );

    modport slave (
        input  entrada_valida, dirA, dirB, datoA, datoB, inmediato, usar_inmediato,
               operacion, dir_destino, escribe_reg,
               exmem_escribe, exmem_dir, exmem_dato,
               memwb_escribe, memwb_dir, memwb_dato,
               vaciar, salida_lista,
        output entrada_lista, salida_valida, operandoA, operandoB,
               seleccionOperacion, dir_destino_out, escribe_reg_out
    );
endinterface

// File: rtl/etapa_operandos_alu.sv
// -----------------------------------------------------------------------------
// etapa_operandos_alu
// ID/EX operand stage in front of the ALU. Resolves EX/MEM and MEM/WB
// forwarding when an instruction is accepted, selects register or
// sign-extended immediate for operand B, and holds up to two entries
// (head + skid) in strict FIFO order.
// Ports:
//   reloj     clock (rising edge)
//   reinicio  synchronous active-high reset
//   bus       etapa_operandos_alu_if.slave (handshakes, operands, forwarding)
// -----------------------------------------------------------------------------
module etapa_operandos_alu #(
    parameter int ANCHO     = 32,
    parameter int ANCHO_OP  = 3,
    parameter int ANCHO_DIR = 5,
    parameter int ANCHO_INM = 16
) (
    input  logic                  reloj,
    input  logic                  reinicio,
    etapa_operandos_alu_if.slave  bus
);

    typedef enum logic [1:0] {
        VACIO = 2'd0,
        UNO   = 2'd1,
        LLENO = 2'd2
    } estado_t;

    typedef struct packed {
        logic [ANCHO-1:0]     a;
        logic [ANCHO-1:0]     b;
        logic [ANCHO_OP-1:0]  op;
        logic [ANCHO_DIR-1:0] dst;
        logic                 we;
    } entrada_t;

    estado_t  estado_q, estado_d;
    entrada_t cabeza_q, cabeza_d;
    entrada_t skid_q, skid_d;
    logic     entrada_lista_q, entrada_lista_d;

    logic     acepta;
    logic     consume;
    entrada_t nueva;

    function automatic logic signed [ANCHO-1:0] extender_signo(
        input logic signed [ANCHO_INM-1:0] inm
    );
        return {{(ANCHO-ANCHO_INM){inm[ANCHO_INM-1]}}, inm};
    endfunction

    // EX/MEM wins over MEM/WB; register 0 is hard-wired to zero so neither a
    // forward nor stale register-file data may ever produce a nonzero value.
    function automatic logic [ANCHO-1:0] resolver(
        input logic [ANCHO_DIR-1:0] dir,
        input logic [ANCHO-1:0]     dato,
        input logic                 ex_we,
        input logic [ANCHO_DIR-1:0] ex_dir,
        input logic [ANCHO-1:0]     ex_dato,
        input logic                 wb_we,
        input logic [ANCHO_DIR-1:0] wb_dir,
        input logic [ANCHO-1:0]     wb_dato
    );
        if (dir == '0)
            return '0;
        else if (ex_we && (ex_dir == dir))
            return ex_dato;
        else if (wb_we && (wb_dir == dir))
            return wb_dato;
        else
            return dato;
    endfunction

    always_comb begin
        acepta  = bus.entrada_valida & entrada_lista_q;
        consume = (estado_q != VACIO) & bus.salida_lista;

        nueva.a   = resolver(bus.dirA, bus.datoA,
                             bus.exmem_escribe, bus.exmem_dir, bus.exmem_dato,
                             bus.memwb_escribe, bus.memwb_dir, bus.memwb_dato);
        nueva.b   = bus.usar_inmediato
                  ? extender_signo(bus.inmediato)
                  : resolver(bus.dirB, bus.datoB,
                             bus.exmem_escribe, bus.exmem_dir, bus.exmem_dato,
                             bus.memwb_escribe, bus.memwb_dir, bus.memwb_dato);
        nueva.op  = bus.operacion;
        nueva.dst = bus.dir_destino;
        nueva.we  = bus.escribe_reg;

        estado_d = estado_q;
        cabeza_d = cabeza_q;
        skid_d   = skid_q;

        // A flush only drops valid; the head registers keep their contents.
        if (bus.vaciar) begin
            estado_d = VACIO;
        end else begin
            unique case (estado_q)
                VACIO: begin
                    if (acepta) begin
                        cabeza_d = nueva;
                        estado_d = UNO;
                    end
                end
                UNO: begin
                    if (acepta && consume) begin
                        cabeza_d = nueva;
                    end else if (acepta) begin
                        skid_d   = nueva;
                        estado_d = LLENO;
                    end else if (consume) begin
                        estado_d = VACIO;
                    end
                end
                LLENO: begin
                    // entrada_lista is low here, so only a consume can happen.
                    if (consume) begin
                        cabeza_d = skid_q;
                        estado_d = UNO;
                    end
                end
                default: estado_d = VACIO;
            endcase
        end

        entrada_lista_d = (estado_d != LLENO);
    end

    always_ff @(posedge reloj) begin
        if (reinicio) begin
            estado_q        <= VACIO;
            cabeza_q        <= '0;
            skid_q          <= '0;
            entrada_lista_q <= 1'b1;
        end else begin
            estado_q        <= estado_d;
            cabeza_q        <= cabeza_d;
            skid_q          <= skid_d;
            entrada_lista_q <= entrada_lista_d;
        end
    end

    assign bus.entrada_lista      = entrada_lista_q;
    assign bus.salida_valida      = (estado_q != VACIO);
    assign bus.operandoA          = cabeza_q.a;
    assign bus.operandoB          = cabeza_q.b;
    assign bus.seleccionOperacion = cabeza_q.op;
    assign bus.dir_destino_out    = cabeza_q.dst;
    assign bus.escribe_reg_out    = cabeza_q.we;

endmodule

// File: tb/tb_etapa_operandos_alu.sv
// -----------------------------------------------------------------------------
// tb_etapa_operandos_alu
// Directed scenarios with literal expectations followed by randomized traffic.
// A queue-based model of the two-entry FIFO predicts every output on each
// falling edge.
// -----------------------------------------------------------------------------
module tb_etapa_operandos_alu;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  d;
        logic        w;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   armed  = 1'b0;

    ent_t q[$];
    ent_t shown;
    bit   m_acc;
    bit   m_con;

    etapa_operandos_alu_if #(.ANCHO(32), .ANCHO_OP(3), .ANCHO_DIR(5), .ANCHO_INM(16)) bus ();

    etapa_operandos_alu #(.ANCHO(32), .ANCHO_OP(3), .ANCHO_DIR(5), .ANCHO_INM(16)) dut (
        .reloj    (clk),
        .reinicio (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] dir, input logic [31:0] dato);
        if (dir == 0) return 32'd0;
        if (bus.exmem_escribe && bus.exmem_dir == dir) return bus.exmem_dato;
        if (bus.memwb_escribe && bus.memwb_dir == dir) return bus.memwb_dato;
        return dato;
    endfunction

    function automatic ent_t calc();
        ent_t e;
        e.a  = fwd(bus.dirA, bus.datoA);
        e.b  = bus.usar_inmediato ? 32'($signed(bus.inmediato)) : fwd(bus.dirB, bus.datoB);
        e.op = bus.operacion;
        e.d  = bus.dir_destino;
        e.w  = bus.escribe_reg;
        return e;
    endfunction

    // Reference model: up to two queued entries, head shown on the outputs;
    // the last shown head persists when the queue empties.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            shown = '0;
        end else begin
            m_acc = bus.entrada_valida && (q.size() < 2);
            m_con = (q.size() > 0) && bus.salida_lista;
            if (bus.vaciar) begin
                q.delete();
            end else begin
                if (m_con) void'(q.pop_front());
                if (m_acc) q.push_back(calc());
            end
            if (q.size() > 0) shown = q[0];
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("salida_valida", 32'(bus.salida_valida), 32'(q.size() != 0));
            chk("entrada_lista", 32'(bus.entrada_lista), 32'(q.size() < 2));
            chk("operandoA", bus.operandoA, shown.a);
            chk("operandoB", bus.operandoB, shown.b);
            chk("seleccionOperacion", 32'(bus.seleccionOperacion), 32'(shown.op));
            chk("dir_destino_out", 32'(bus.dir_destino_out), 32'(shown.d));
            chk("escribe_reg_out", 32'(bus.escribe_reg_out), 32'(shown.w));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.entrada_valida = 0; bus.dirA = 0; bus.dirB = 0; bus.datoA = 0; bus.datoB = 0;
        bus.inmediato = 0; bus.usar_inmediato = 0; bus.operacion = 0; bus.dir_destino = 0;
        bus.escribe_reg = 0; bus.exmem_escribe = 0; bus.exmem_dir = 0; bus.exmem_dato = 0;
        bus.memwb_escribe = 0; bus.memwb_dir = 0; bus.memwb_dato = 0; bus.vaciar = 0;
        bus.salida_lista = 0;
    endtask

    task automatic zeros_check(input string tag);
        chk({tag, "_valid"}, 32'(bus.salida_valida), 32'd0);
        chk({tag, "_lista"}, 32'(bus.entrada_lista), 32'd1);
        chk({tag, "_A"}, bus.operandoA, 32'd0);
        chk({tag, "_B"}, bus.operandoB, 32'd0);
        chk({tag, "_op"}, 32'(bus.seleccionOperacion), 32'd0);
        chk({tag, "_dst"}, 32'(bus.dir_destino_out), 32'd0);
        chk({tag, "_we"}, 32'(bus.escribe_reg_out), 32'd0);
    endtask

    task automatic drain();
        bus.entrada_valida = 0;
        bus.salida_lista   = 1;
        cycle(); cycle();
        bus.salida_lista   = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        cycle(); cycle();
        zeros_check("reset");
        armed = 1;
        rst = 0;

        // 1: single accept
        bus.entrada_valida = 1; bus.dirA = 3; bus.datoA = 7; bus.dirB = 4; bus.datoB = 5;
        bus.operacion = 3'b000; bus.dir_destino = 9; bus.escribe_reg = 1;
        cycle();
        bus.entrada_valida = 0;
        chk("t1_valid", 32'(bus.salida_valida), 32'd1);
        chk("t1_A", bus.operandoA, 32'd7);
        chk("t1_B", bus.operandoB, 32'd5);
        chk("t1_op", 32'(bus.seleccionOperacion), 32'd0);
        chk("t1_dst", 32'(bus.dir_destino_out), 32'd9);
        drain();

        // 2: forwarding priority
        bus.entrada_valida = 1; bus.dirA = 8; bus.datoA = 32'h11;
        bus.exmem_escribe = 1; bus.exmem_dir = 8; bus.exmem_dato = 32'hAA;
        bus.memwb_escribe = 1; bus.memwb_dir = 8; bus.memwb_dato = 32'hBB;
        cycle();
        bus.entrada_valida = 0;
        chk("t2_exmem", bus.operandoA, 32'hAA);
        drain();
        bus.entrada_valida = 1; bus.exmem_escribe = 0;
        cycle();
        bus.entrada_valida = 0;
        chk("t2_memwb", bus.operandoA, 32'hBB);
        drain();

        // 3: register zero and immediate sign extension
        idle();
        bus.entrada_valida = 1; bus.dirA = 0; bus.datoA = 32'h1234;
        bus.exmem_escribe = 1; bus.exmem_dir = 0; bus.exmem_dato = 32'h55;
        bus.dirB = 2; bus.datoB = 32'h77; bus.usar_inmediato = 1; bus.inmediato = 16'hFFFE;
        bus.operacion = 3'b101;
        cycle();
        bus.entrada_valida = 0;
        chk("t3_A_reg0", bus.operandoA, 32'd0);
        chk("t3_B_imm", bus.operandoB, 32'hFFFF_FFFE);
        chk("t3_op", 32'(bus.seleccionOperacion), 32'd5);
        drain();

        // 4: backpressure, three issued, two held, FIFO release
        idle();
        bus.dirA = 1; bus.entrada_valida = 1;
        for (int k = 0; k < 3; k++) begin
            bus.datoA = 32'(100 + k);
            cycle();
        end
        bus.entrada_valida = 0;
        chk("t4_full_lista", 32'(bus.entrada_lista), 32'd0);
        chk("t4_head0", bus.operandoA, 32'd100);
        bus.salida_lista = 1;
        cycle();
        chk("t4_head1", bus.operandoA, 32'd101);
        chk("t4_head1_valid", 32'(bus.salida_valida), 32'd1);
        cycle();
        chk("t4_empty", 32'(bus.salida_valida), 32'd0);
        bus.salida_lista = 0;

        // 5: flush while full with consume and accept in the same cycle
        bus.entrada_valida = 1;
        for (int k = 0; k < 2; k++) begin
            bus.datoA = 32'(200 + k);
            cycle();
        end
        bus.vaciar = 1; bus.salida_lista = 1; bus.datoA = 32'd300;
        cycle();
        bus.vaciar = 0; bus.entrada_valida = 0;
        chk("t5_valid", 32'(bus.salida_valida), 32'd0);
        chk("t5_lista", 32'(bus.entrada_lista), 32'd1);
        chk("t5_data_kept", bus.operandoA, 32'd200);
        cycle();
        chk("t5_no_reappear", 32'(bus.salida_valida), 32'd0);
        bus.salida_lista = 0;

        // 6: reset while full with a pending request
        bus.entrada_valida = 1; bus.operacion = 3'b111; bus.escribe_reg = 1; bus.dir_destino = 5;
        for (int k = 0; k < 2; k++) begin
            bus.datoA = 32'(400 + k);
            cycle();
        end
        rst = 1;
        cycle();
        zeros_check("t6");
        rst = 0;
        idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.entrada_valida = ($urandom_range(0, 9) < 7);
            bus.dirA           = 5'($urandom_range(0, 3));
            bus.dirB           = 5'($urandom_range(0, 3));
            bus.datoA          = $urandom;
            bus.datoB          = $urandom;
            bus.inmediato      = 16'($urandom);
            bus.usar_inmediato = $urandom_range(0, 1);
            bus.operacion      = 3'($urandom);
            bus.dir_destino    = 5'($urandom);
            bus.escribe_reg    = $urandom_range(0, 1);
            bus.exmem_escribe  = $urandom_range(0, 1);
            bus.exmem_dir      = 5'($urandom_range(0, 3));
            bus.exmem_dato     = $urandom;
            bus.memwb_escribe  = $urandom_range(0, 1);
            bus.memwb_dir      = 5'($urandom_range(0, 3));
            bus.memwb_dato     = $urandom;
            bus.vaciar         = ($urandom_range(0, 19) == 0);
            bus.salida_lista   = ($urandom_range(0, 9) < 6);
            rst                = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 0;
        idle();
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
